// File: rtl/sincos_quadrant_post_if.sv
// Bundles the tag queue, sincos completion and corrected-result handshake
// of sincos_quadrant_post; master drives the inputs, slave is the block itself.
interface sincos_quadrant_post_if;
  logic        tag_push;
  logic [1:0]  tag_q;
  logic        tag_full;
  logic        sine_done;
  logic [31:0] sine_result;
  logic [31:0] cosine_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sin;
  logic [31:0] out_cos;
  logic        err_orphan;
  logic        err_drop;

  modport master (
    output tag_push, tag_q, sine_done, sine_result, cosine_result, out_ready,
    input  tag_full, out_valid, out_sin, out_cos, err_orphan, err_drop
  );

  modport slave (
    input  tag_push, tag_q, sine_done, sine_result, cosine_result, out_ready,
    output tag_full, out_valid, out_sin, out_cos, err_orphan, err_drop
  );
endinterface

// File: rtl/sincos_quadrant_post.sv
// Pairs each sincos completion with its queued quadrant tag, applies the
// quadrant swap/negate to the fp32 pair and buffers results behind valid/ready.
module sincos_quadrant_post #(
  parameter int TAG_DEPTH = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sincos_quadrant_post_if.slave bus
);

  localparam int TPW = $clog2(TAG_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int OCW = OPW + 1;

  localparam logic [TCW-1:0] TAG_CNT_FULL = TCW'(TAG_DEPTH);
  localparam logic [TCW-1:0] TAG_CNT_ONE  = TCW'(1);
  localparam logic [TPW-1:0] TAG_PTR_ONE  = TPW'(1);
  localparam logic [OCW-1:0] OUT_CNT_FULL = OCW'(OUT_DEPTH);
  localparam logic [OCW-1:0] OUT_CNT_ONE  = OCW'(1);
  localparam logic [OPW-1:0] OUT_PTR_ONE  = OPW'(1);

  // NaNs keep their sign; everything else flips bit 31.
  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    logic is_nan;
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    return is_nan ? x : {~x[31], x[30:0]};
  endfunction

  function automatic logic [31:0] fp_zero_fix(input logic [31:0] x);
    return (x[30:0] == 31'd0) ? 32'd0 : x;
  endfunction

  // Returns {sin(x), cos(x)} from sin(r), cos(r) and quadrant k.
  function automatic logic [63:0] quad_correct(input logic [1:0]  q,
                                               input logic [31:0] s,
                                               input logic [31:0] c);
    logic [31:0] rs;
    logic [31:0] rc;
    case (q)
      2'd0:    begin rs = s;         rc = c;         end
      2'd1:    begin rs = c;         rc = fp_neg(s); end
      2'd2:    begin rs = fp_neg(s); rc = fp_neg(c); end
      default: begin rs = fp_neg(c); rc = s;         end
    endcase
    return {fp_zero_fix(rs), fp_zero_fix(rc)};
  endfunction

  logic             done_q;
  logic [1:0]       tag_mem_q [TAG_DEPTH];
  logic [TPW-1:0]   tag_wp_q, tag_wp_d;
  logic [TPW-1:0]   tag_rp_q, tag_rp_d;
  logic [TCW-1:0]   tag_cnt_q, tag_cnt_d;

  logic [31:0]      sin_mem_q [OUT_DEPTH];
  logic [31:0]      cos_mem_q [OUT_DEPTH];
  logic [OPW-1:0]   out_wp_q, out_wp_d;
  logic [OPW-1:0]   out_rp_q, out_rp_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  logic [31:0]      head_sin_q, head_sin_d;
  logic [31:0]      head_cos_q, head_cos_d;

  logic             err_orphan_q, err_orphan_d;
  logic             err_drop_q, err_drop_d;

  logic             done_ev;
  logic             tag_empty;
  logic             tag_full;
  logic             tag_pop;
  logic             tag_push_ok;
  logic             tag_ovf;
  logic             out_full;
  logic             out_valid;
  logic             out_pop;
  logic             out_wr;
  logic             out_lost;
  logic [63:0]      corr;

  assign done_ev     = bus.sine_done & ~done_q;
  assign tag_empty   = (tag_cnt_q == '0);
  assign tag_full    = (tag_cnt_q == TAG_CNT_FULL);
  assign tag_pop     = done_ev & ~tag_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign tag_push_ok = bus.tag_push & (~tag_full | tag_pop);
  assign tag_ovf     = bus.tag_push & tag_full & ~tag_pop;

  assign out_full    = (out_cnt_q == OUT_CNT_FULL);
  assign out_valid   = (out_cnt_q != '0);
  assign out_pop     = out_valid & bus.out_ready;
  assign out_wr      = tag_pop & (~out_full | out_pop);
  assign out_lost    = tag_pop & ~out_wr;

  assign corr = quad_correct(tag_mem_q[tag_rp_q], bus.sine_result, bus.cosine_result);

  always_comb begin
    tag_wp_d  = tag_wp_q;
    tag_rp_d  = tag_rp_q;
    tag_cnt_d = tag_cnt_q;
    if (tag_push_ok) tag_wp_d = tag_wp_q + TAG_PTR_ONE;
    if (tag_pop)     tag_rp_d = tag_rp_q + TAG_PTR_ONE;
    case ({tag_push_ok, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + TAG_CNT_ONE;
      2'b01:   tag_cnt_d = tag_cnt_q - TAG_CNT_ONE;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // The head register tracks what the FIFO front will be after this edge.
  always_comb begin
    out_wp_d   = out_wp_q;
    out_rp_d   = out_rp_q;
    out_cnt_d  = out_cnt_q;
    head_sin_d = head_sin_q;
    head_cos_d = head_cos_q;
    if (out_wr)  out_wp_d = out_wp_q + OUT_PTR_ONE;
    if (out_pop) out_rp_d = out_rp_q + OUT_PTR_ONE;
    case ({out_wr, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OUT_CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - OUT_CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
    if (out_pop) begin
      if (out_cnt_q == OUT_CNT_ONE) begin
        if (out_wr) begin
          head_sin_d = corr[63:32];
          head_cos_d = corr[31:0];
        end
      end else begin
        head_sin_d = sin_mem_q[out_rp_q + OUT_PTR_ONE];
        head_cos_d = cos_mem_q[out_rp_q + OUT_PTR_ONE];
      end
    end else if (!out_valid && out_wr) begin
      head_sin_d = corr[63:32];
      head_cos_d = corr[31:0];
    end
  end

  always_comb begin
    err_orphan_d = err_orphan_q | (done_ev & tag_empty);
    err_drop_d   = err_drop_q | tag_ovf | out_lost;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      done_q       <= 1'b0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      tag_cnt_q    <= '0;
      out_wp_q     <= '0;
      out_rp_q     <= '0;
      out_cnt_q    <= '0;
      head_sin_q   <= '0;
      head_cos_q   <= '0;
      err_orphan_q <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      done_q       <= bus.sine_done;
      tag_wp_q     <= tag_wp_d;
      tag_rp_q     <= tag_rp_d;
      tag_cnt_q    <= tag_cnt_d;
      out_wp_q     <= out_wp_d;
      out_rp_q     <= out_rp_d;
      out_cnt_q    <= out_cnt_d;
      head_sin_q   <= head_sin_d;
      head_cos_q   <= head_cos_d;
      err_orphan_q <= err_orphan_d;
      err_drop_q   <= err_drop_d;
    end
  end

  // Storage arrays carry no reset; the counts decide what is live.
  always_ff @(posedge clk) begin
    if (n_rst && tag_push_ok) tag_mem_q[tag_wp_q] <= bus.tag_q;
    if (n_rst && out_wr) begin
      sin_mem_q[out_wp_q] <= corr[63:32];
      cos_mem_q[out_wp_q] <= corr[31:0];
    end
  end

  assign bus.tag_full   = tag_full;
  assign bus.out_valid  = out_valid;
  assign bus.out_sin    = head_sin_q;
  assign bus.out_cos    = head_cos_q;
  assign bus.err_orphan = err_orphan_q;
  assign bus.err_drop   = err_drop_q;

endmodule

// File: tb/tb_sincos_quadrant_post.sv
// Directed bench for sincos_quadrant_post: hand-computed vectors covering
// reset, quadrant correction, FIFO full/empty corners and error flags.
module tb_sincos_quadrant_post;
  logic clk;
  logic n_rst;
  int   total;
  int   bad;

  sincos_quadrant_post_if bus ();

  sincos_quadrant_post #(.TAG_DEPTH(4), .OUT_DEPTH(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    n_rst             = 1'b0;
    bus.tag_push      = 1'b0;
    bus.tag_q         = 2'd0;
    bus.sine_done     = 1'b0;
    bus.sine_result   = 32'd0;
    bus.cosine_result = 32'd0;
    bus.out_ready     = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic push(input logic [1:0] q);
    bus.tag_push = 1'b1;
    bus.tag_q    = q;
    step();
    bus.tag_push = 1'b0;
  endtask

  // One low cycle guarantees a fresh rising edge; rdy applies in the done cycle only.
  task automatic do_done(input logic [31:0] s, input logic [31:0] c, input logic rdy);
    bus.sine_done = 1'b0;
    step();
    bus.sine_result   = s;
    bus.cosine_result = c;
    bus.sine_done     = 1'b1;
    bus.out_ready     = rdy;
    step();
    bus.sine_done = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic [1:0] q,
                      input logic [31:0] s, input logic [31:0] c,
                      input logic [31:0] es, input logic [31:0] ec);
    push(q);
    do_done(s, c, 1'b0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sin"}, bus.out_sin, es);
    chk({tag, "_cos"}, bus.out_cos, ec);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sin", bus.out_sin, 32'd0);
    chk("rst_cos", bus.out_cos, 32'd0);
    chk("rst_tag_full", 32'(bus.tag_full), 32'd0);
    chk("rst_orphan", 32'(bus.err_orphan), 32'd0);
    chk("rst_drop", 32'(bus.err_drop), 32'd0);

    // Quadrant corrections
    xact("q0", 2'd0, 32'h3F3504F3, 32'h3F3504F3, 32'h3F3504F3, 32'h3F3504F3);
    xact("q1", 2'd1, 32'h3F800000, 32'h00000000, 32'h00000000, 32'hBF800000);
    xact("q2", 2'd2, 32'h3F800000, 32'h00000000, 32'hBF800000, 32'h00000000);
    xact("q3", 2'd3, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000);
    xact("q2neg", 2'd2, 32'hBFC00000, 32'h40200000, 32'h3FC00000, 32'hC0200000);

    // Output FIFO full: loss, then accept when a pop frees the slot
    push(2'd0);
    push(2'd0);
    push(2'd0);
    push(2'd0);
    do_done(32'h40000000, 32'h40400000, 1'b0);
    do_done(32'h40800000, 32'h40A00000, 1'b0);
    chk("ofull_no_drop", 32'(bus.err_drop), 32'd0);
    do_done(32'h41000000, 32'h41100000, 1'b0);
    chk("ofull_drop", 32'(bus.err_drop), 32'd1);
    chk("ofull_head_sin", bus.out_sin, 32'h40000000);
    chk("ofull_head_cos", bus.out_cos, 32'h40400000);
    do_done(32'h41200000, 32'h41300000, 1'b1);
    chk("ofull_retry_head", bus.out_sin, 32'h40800000);
    chk("ofull_retry_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("ofull_d_sin", bus.out_sin, 32'h41200000);
    chk("ofull_d_cos", bus.out_cos, 32'h41300000);
    step();
    bus.out_ready = 1'b0;
    chk("ofull_empty", 32'(bus.out_valid), 32'd0);
    chk("ofull_hold_sin", bus.out_sin, 32'h41200000);

    // Tag FIFO overflow
    do_reset();
    push(2'd1);
    push(2'd1);
    push(2'd1);
    chk("tag_3_notfull", 32'(bus.tag_full), 32'd0);
    push(2'd1);
    chk("tag_4_full", 32'(bus.tag_full), 32'd1);
    chk("tag_4_nodrop", 32'(bus.err_drop), 32'd0);
    push(2'd2);
    chk("tag_5_drop", 32'(bus.err_drop), 32'd1);
    chk("tag_5_full", 32'(bus.tag_full), 32'd1);

    // Push and done together while full
    do_reset();
    push(2'd1);
    push(2'd1);
    push(2'd1);
    push(2'd1);
    step();
    bus.tag_push      = 1'b1;
    bus.tag_q         = 2'd2;
    bus.sine_result   = 32'h3F800000;
    bus.cosine_result = 32'h00000000;
    bus.sine_done     = 1'b1;
    step();
    bus.tag_push  = 1'b0;
    bus.sine_done = 1'b0;
    chk("pd_full", 32'(bus.tag_full), 32'd1);
    chk("pd_nodrop", 32'(bus.err_drop), 32'd0);
    chk("pd_valid", 32'(bus.out_valid), 32'd1);
    chk("pd_cos", bus.out_cos, 32'hBF800000);
    do_done(32'h3F800000, 32'h00000000, 1'b1);
    chk("pd_pop1_notfull", 32'(bus.tag_full), 32'd0);
    do_done(32'h3F800000, 32'h00000000, 1'b1);
    do_done(32'h3F800000, 32'h00000000, 1'b1);
    chk("pd_pop3_cos", bus.out_cos, 32'hBF800000);
    do_done(32'h3F800000, 32'h00000000, 1'b1);
    chk("pd_pop4_sin", bus.out_sin, 32'hBF800000);
    chk("pd_pop4_cos", bus.out_cos, 32'h00000000);
    chk("pd_pop4_nodrop", 32'(bus.err_drop), 32'd0);

    // Orphan done with empty tag FIFO
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("orph_pre_empty", 32'(bus.out_valid), 32'd0);
    chk("orph_pre_flag", 32'(bus.err_orphan), 32'd0);
    do_done(32'h40400000, 32'h40400000, 1'b0);
    chk("orph_flag", 32'(bus.err_orphan), 32'd1);
    chk("orph_valid", 32'(bus.out_valid), 32'd0);

    // Held done pops once; NaN never negated
    do_reset();
    push(2'd0);
    push(2'd2);
    bus.sine_result   = 32'h3F800000;
    bus.cosine_result = 32'h3F800000;
    bus.sine_done     = 1'b1;
    step();
    step();
    step();
    bus.sine_done = 1'b0;
    chk("held_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("held_one_entry", 32'(bus.out_valid), 32'd0);
    do_done(32'h7FC00000, 32'h7FC00000, 1'b0);
    chk("nan_valid", 32'(bus.out_valid), 32'd1);
    chk("nan_sin", bus.out_sin, 32'h7FC00000);
    chk("nan_cos", bus.out_cos, 32'h7FC00000);
    chk("held_no_orphan", 32'(bus.err_orphan), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
